x_mux_trigger_seq: RTL and testbench
====================================

// Module: x_mux_trigger_seq
// PURPOSE
//   Sequencer for the fast mux delay line. Accepts a sweep command (start code,
//   step, pulse count) and drives the delay line's 32-bit tap-select word and
//   trigger. Guarantees the select word is stable for a setup window before
//   every trigger rise, and for a hold window after every fall.
//   Sits between the host/UART register block and the delay line.
// PARAMETERS
//   DATA_W     32  width of delay-line select word (o_data)
//   CNT_W      16  width of pulse count / index
//   SETUP_CYC  4   cycles o_data is stable before o_trigger rises (>=1)
//   HIGH_CYC   8   cycles o_trigger is high per pulse (>=1)
//   HOLD_CYC   4   cycles o_data is stable after o_trigger falls (>=1)
// PORTS
//   i_clk        in   1       clock
//   i_rst        in   1       synchronous reset, active high
//   i_cmd_valid  in   1       command valid
//   o_cmd_ready  out  1       command ready (high only in IDLE, low during reset)
//   i_cmd_start  in   DATA_W  select word for first pulse
//   i_cmd_step   in   DATA_W  added to select word between pulses
//   i_cmd_count  in   CNT_W   number of pulses (0 = no-op)
//   i_abort      in   1       abort running sweep (sampled only when busy)
//   o_data       out  DATA_W  delay-line select word
//   o_trigger    out  1       delay-line trigger
//   o_busy       out  1       sweep in progress
//   o_done       out  1       1-cycle pulse at sweep end (normal or abort)
//   o_aborted    out  1       valid with o_done: sweep was aborted
//   o_pulse_idx  out  CNT_W   index of current pulse (0-based)
// BEHAVIOUR
//   Reset: o_data=0, o_trigger=0, o_busy=0, o_done=0, o_aborted=0,
//     o_pulse_idx=0, state=IDLE. Reset mid-sweep forces these next edge.
//   All outputs are registered. Accept = i_cmd_valid & o_cmd_ready at edge T.
//   FSM: IDLE -> SETUP -> FIRE -> HOLD -> (SETUP | IDLE).
//   IDLE: o_cmd_ready=1, o_busy=0, o_data holds last value. On accept with
//     count>0: o_data<=start, o_pulse_idx<=0, remaining<=count, go SETUP.
//     On accept with count==0: stay IDLE, o_done=1 at T+1, o_data unchanged.
//   SETUP: SETUP_CYC cycles, o_trigger=0, then FIRE.
//   FIRE: HIGH_CYC cycles, o_trigger=1, then HOLD.
//   HOLD: HOLD_CYC cycles, o_trigger=0. On last cycle: if remaining>1,
//     o_data<=o_data+step (mod 2^DATA_W, wraps silently), o_pulse_idx++,
//     remaining--, go SETUP. Else go IDLE with o_done=1 for one cycle.
//   Timing: period P=SETUP_CYC+HIGH_CYC+HOLD_CYC. Accept at T: pulse k
//     trigger high for cycles T+k*P+SETUP_CYC+1 .. T+k*P+SETUP_CYC+HIGH_CYC.
//     o_done=1 and o_cmd_ready=1 at T+N*P+1.
//   Invariant: o_data changes only in IDLE accept or HOLD->SETUP edge;
//     never while o_trigger=1 or within setup/hold windows.
//   Abort (busy only): in SETUP -> IDLE next edge, o_done=1, o_aborted=1,
//     no trigger issued. In FIRE -> o_trigger low next edge, full HOLD_CYC
//     served, then IDLE with o_done=1, o_aborted=1. In HOLD -> finish HOLD,
//     no further pulses, o_done=1, o_aborted=1.
//   i_abort in IDLE ignored; i_cmd_valid while busy ignored (not queued).
//   o_aborted cleared on next accept.
// TESTING (defaults, P=16)
//   Reset held 3 cycles mid-FIRE -> o_trigger=0, o_data=0, o_busy=0 next edge.
//   Accept start=0xAAAAAAAA,step=0,count=1 at T -> trigger high T+5..T+12,
//     o_data=0xAAAAAAAA from T+1, o_done at T+17.
//   start=0,step=1,count=3 -> o_data 0,1,2, changes at T+17,T+33 only;
//     o_pulse_idx 0,1,2; 3 trigger pulses of 8 cycles; o_done at T+49.
//   start=0xFFFFFFFF,step=2,count=2 -> second pulse o_data=0x00000001 (wrap).
//   count=0 -> o_done at T+1, o_aborted=0, no trigger, o_data unchanged.
//   Abort at T+7 (in FIRE) -> trigger low T+8, o_done=o_aborted=1 at T+12;
//     abort at T+2 (SETUP) -> o_done=1 at T+3, no trigger. Checker asserts
//     o_data stable while trigger high and within 4 cycles either side.

Source files
------------

// File: rtl/x_mux_trigger_seq.sv
// rtl/x_mux_trigger_seq.sv - sweep sequencer driving the fast mux delay line select word and trigger
//
// Purpose:
//   Accepts one sweep command (start word, step, pulse count) and emits
//   count trigger pulses. The select word is loaded before the first pulse and
//   advanced by step between pulses. The word is held stable for SETUP_CYC cycles
//   before each trigger rise and HOLD_CYC cycles after each fall. A running sweep
//   can be aborted without ever truncating a trigger pulse's hold window.
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous reset, active high
//   i_cmd_valid  command valid
//   o_cmd_ready  command ready (registered, high only while idle)
//   i_cmd_start  select word for the first pulse
//   i_cmd_step   increment applied to the select word between pulses
//   i_cmd_count  number of pulses, 0 = no-op that just reports done
//   i_abort      abort request, looked at only while a sweep is running
//   o_data       delay-line select word
//   o_trigger    delay-line trigger
//   o_busy       sweep in progress
//   o_done       one-cycle end-of-sweep pulse (normal, no-op or aborted)
//   o_aborted    qualifies o_done: sweep ended by abort (held until next accept)
//   o_pulse_idx  0-based index of the current pulse

module x_mux_trigger_seq #(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int SETUP_CYC = 4,
  parameter int HIGH_CYC  = 8,
  parameter int HOLD_CYC  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [DATA_W-1:0] i_cmd_start,
  input  logic [DATA_W-1:0] i_cmd_step,
  input  logic [CNT_W-1:0]  i_cmd_count,
  input  logic              i_abort,
  output logic [DATA_W-1:0] o_data,
  output logic              o_trigger,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted,
  output logic [CNT_W-1:0]  o_pulse_idx
);

  // One phase counter is shared by SETUP, FIRE and HOLD, so it is sized for
  // the longest of the three windows.
  localparam int MAX_PH = (SETUP_CYC > HIGH_CYC)
                        ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                        : ((HIGH_CYC  > HOLD_CYC) ? HIGH_CYC  : HOLD_CYC);
  localparam int PH_W   = (MAX_PH < 2) ? 1 : $clog2(MAX_PH);

  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0] HIGH_LAST  = PH_W'(HIGH_CYC - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_FIRE  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  logic [PH_W-1:0]   r_phase;
  logic [CNT_W-1:0]  r_remaining;
  logic [DATA_W-1:0] r_step;
  logic              r_abort_pend;
  logic [DATA_W-1:0] r_data;
  logic              r_trigger;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;
  logic [CNT_W-1:0]  r_pulse_idx;
  logic              r_cmd_ready;

  logic              w_accept;
  logic              w_phase_end;
  logic              w_more;
  logic              w_stop;

  assign w_accept = i_cmd_valid & r_cmd_ready;
  // Another pulse follows only if more remain and nobody asked to stop; an
  // abort raised in FIRE is remembered in r_abort_pend until HOLD finishes.
  assign w_more   = (r_remaining > CNT_W'(1));
  assign w_stop   = r_abort_pend | i_abort;

  always_comb begin
    w_phase_end = 1'b0;
    case (r_state)
      S_SETUP: w_phase_end = (r_phase == SETUP_LAST);
      S_FIRE:  w_phase_end = (r_phase == HIGH_LAST);
      S_HOLD:  w_phase_end = (r_phase == HOLD_LAST);
      default: w_phase_end = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_remaining  <= '0;
      r_step       <= '0;
      r_abort_pend <= 1'b0;
      r_data       <= '0;
      r_trigger    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_pulse_idx  <= '0;
      r_cmd_ready  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_aborted <= 1'b0;
            if (i_cmd_count != '0) begin
              // Select word goes out with the state change, so the first
              // SETUP window already sees the new word.
              r_data       <= i_cmd_start;
              r_step       <= i_cmd_step;
              r_remaining  <= i_cmd_count;
              r_pulse_idx  <= '0;
              r_phase      <= '0;
              r_abort_pend <= 1'b0;
              r_busy       <= 1'b1;
              r_cmd_ready  <= 1'b0;
              r_state      <= S_SETUP;
            end else begin
              r_done <= 1'b1;
            end
          end
        end

        S_SETUP: begin
          if (i_abort) begin
            // Trigger has not risen yet, so it is safe to drop out at once.
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_aborted   <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_phase     <= '0;
          end else if (w_phase_end) begin
            r_phase   <= '0;
            r_trigger <= 1'b1;
            r_state   <= S_FIRE;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end

        S_FIRE: begin
          // An abort cuts the high time short but still enters HOLD, so the
          // delay line always sees a full hold window after the fall.
          if (i_abort || w_phase_end) begin
            r_phase      <= '0;
            r_trigger    <= 1'b0;
            r_abort_pend <= i_abort;
            r_state      <= S_HOLD;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end

        S_HOLD: begin
          if (i_abort) begin
            r_abort_pend <= 1'b1;
          end
          if (w_phase_end) begin
            r_phase <= '0;
            if (w_more && !w_stop) begin
              // The only mid-sweep update of the select word; trigger is low
              // and the hold window has just been served.
              r_data      <= r_data + r_step;
              r_pulse_idx <= r_pulse_idx + CNT_W'(1);
              r_remaining <= r_remaining - CNT_W'(1);
              r_state     <= S_SETUP;
            end else begin
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_aborted    <= w_stop;
              r_abort_pend <= 1'b0;
              r_cmd_ready  <= 1'b1;
            end
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_data      = r_data;
  assign o_trigger   = r_trigger;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_aborted   = r_aborted;
  assign o_pulse_idx = r_pulse_idx;

endmodule

// File: tb/tb_x_mux_trigger_seq.sv
// tb/tb_x_mux_trigger_seq.sv - self-checking bench for x_mux_trigger_seq
module tb_x_mux_trigger_seq;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int SC = 4;
  localparam int HC = 8;
  localparam int OC = 4;
  localparam int P  = SC + HC + OC;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [DW-1:0] i_cmd_start;
  logic [DW-1:0] i_cmd_step;
  logic [CW-1:0] i_cmd_count;
  logic          i_abort;
  logic [DW-1:0] o_data;
  logic          o_trigger;
  logic          o_busy;
  logic          o_done;
  logic          o_aborted;
  logic [CW-1:0] o_pulse_idx;

  always #5 clk = ~clk;

  x_mux_trigger_seq #(
    .DATA_W(DW), .CNT_W(CW), .SETUP_CYC(SC), .HIGH_CYC(HC), .HOLD_CYC(OC)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_start(i_cmd_start), .i_cmd_step(i_cmd_step), .i_cmd_count(i_cmd_count),
    .i_abort(i_abort), .o_data(o_data), .o_trigger(o_trigger), .o_busy(o_busy),
    .o_done(o_done), .o_aborted(o_aborted), .o_pulse_idx(o_pulse_idx)
  );

  typedef struct packed {
    logic          trig;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          ready;
    logic [CW-1:0] idx;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [DW-1:0] start;
    logic [DW-1:0] step;
    logic [CW-1:0] count;
    int            abort_at;
    bit            poke;
    logic [DW-1:0] exp_final;
    int            exp_done_n;
    bit            exp_aborted;
    int            exp_rises;
  } vec_t;

  int            n_vec = 0;
  int            n_bad = 0;
  exp_t          sb_q[$];
  logic [DW-1:0] m_data = '0;
  logic [CW-1:0] m_idx  = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  function automatic exp_t actual();
    return {o_trigger, o_busy, o_done, o_aborted, o_cmd_ready, o_pulse_idx, o_data};
  endfunction

  task automatic wait_ready(input string name);
    for (int i = 0; i < 10 && o_cmd_ready !== 1'b1; i++) tick();
    check({name, " ready"}, 64'(o_cmd_ready), 64'd1);
  endtask

  // Expected per-cycle outputs come from the sweep timing formula: cycle n
  // after accept belongs to pulse (n-1)/P at phase (n-1)%P.
  task automatic run_vec(input int vi, input vec_t v);
    exp_t          e;
    exp_t          a;
    int            n_done;
    int            k;
    int            ph;
    int            rises;
    int            got_done_n;
    logic          prev_trig;
    logic [DW-1:0] got_final;
    logic          got_ab;
    logic [DW-1:0] kk;

    wait_ready($sformatf("vec%0d", vi));

    if (v.abort_at < 0) begin
      n_done = int'(v.count) * P + 1;
    end else begin
      ph = (v.abort_at - 1) % P;
      k  = (v.abort_at - 1) / P;
      if (ph < SC)           n_done = v.abort_at + 1;
      else if (ph < SC + HC) n_done = v.abort_at + OC + 1;
      else                   n_done = (k + 1) * P + 1;
    end

    for (int n = 1; n < n_done; n++) begin
      k  = (n - 1) / P;
      ph = (n - 1) % P;
      kk = DW'(k);
      e.trig    = (ph >= SC) && (ph < SC + HC) && !(v.abort_at > 0 && n > v.abort_at);
      e.busy    = 1'b1;
      e.done    = 1'b0;
      e.aborted = 1'b0;
      e.ready   = 1'b0;
      e.idx     = CW'(k);
      e.data    = v.start + kk * v.step;
      sb_q.push_back(e);
    end
    if (v.count != '0) begin
      k      = (n_done - 2) / P;
      kk     = DW'(k);
      m_data = v.start + kk * v.step;
      m_idx  = CW'(k);
    end
    e = '{trig: 1'b0, busy: 1'b0, done: 1'b1, aborted: (v.abort_at > 0), ready: 1'b1,
          idx: m_idx, data: m_data};
    sb_q.push_back(e);
    e.done = 1'b0;
    sb_q.push_back(e);

    i_cmd_valid = 1'b1;
    i_cmd_start = v.start;
    i_cmd_step  = v.step;
    i_cmd_count = v.count;
    tick();
    i_cmd_valid = 1'b0;
    i_cmd_start = $urandom;
    i_cmd_step  = $urandom;
    i_cmd_count = CW'($urandom_range(1, 5));

    rises      = 0;
    prev_trig  = 1'b0;
    got_done_n = -1;
    got_final  = '0;
    got_ab     = 1'b0;
    for (int n = 1; n <= n_done + 1; n++) begin
      e = sb_q.pop_front();
      a = actual();
      check($sformatf("vec%0d cyc%0d {trig,busy,done,abt,rdy,idx,data}", vi, n), 64'(a), 64'(e));
      if (o_trigger && !prev_trig) rises++;
      prev_trig = o_trigger;
      if (o_done === 1'b1 && got_done_n < 0) begin
        got_done_n = n;
        got_final  = o_data;
        got_ab     = o_aborted;
      end
      i_abort     = (n == v.abort_at);
      i_cmd_valid = v.poke && (n >= 2) && (n <= 5);
      if (i_cmd_valid) begin
        i_cmd_start = $urandom;
        i_cmd_count = CW'($urandom_range(0, 5));
      end
      if (n <= n_done) tick();
    end
    i_abort     = 1'b0;
    i_cmd_valid = 1'b0;

    check($sformatf("vec%0d done cycle", vi), 64'(got_done_n), 64'(v.exp_done_n));
    check($sformatf("vec%0d final data", vi), 64'(got_final), 64'(v.exp_final));
    check($sformatf("vec%0d aborted", vi), 64'(got_ab), 64'(v.exp_aborted));
    check($sformatf("vec%0d trigger pulses", vi), 64'(rises), 64'(v.exp_rises));
  endtask

  // Stability checker: o_data must not move within SC cycles before a high
  // trigger cycle, nor within OC cycles after the last high cycle.
  int            mon_cyc     = 0;
  int            last_change = -1000;
  int            last_high   = -1000;
  logic [DW-1:0] prev_d      = '0;

  always @(negedge clk) begin
    mon_cyc++;
    if (i_rst !== 1'b0) begin
      last_change = -1000;
      last_high   = -1000;
      prev_d      = o_data;
    end else begin
      if (o_data !== prev_d) begin
        n_vec++;
        if (mon_cyc - last_high <= OC) begin
          n_bad++;
          $display("FAIL hold window: data changed %0d cycles after trigger high, want > %0d",
                   mon_cyc - last_high, OC);
        end
        last_change = mon_cyc;
      end
      if (o_trigger === 1'b1) begin
        n_vec++;
        if (mon_cyc - last_change < SC) begin
          n_bad++;
          $display("FAIL setup window: trigger high %0d cycles after data change, want >= %0d",
                   mon_cyc - last_change, SC);
        end
        last_high = mon_cyc;
      end
      prev_d = o_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t tbl[8];

  initial begin
    tbl[0] = '{32'hAAAA_AAAA, 32'h0000_0000, 16'd1, -1, 1'b0, 32'hAAAA_AAAA, 17, 1'b0, 1};
    tbl[1] = '{32'h0000_0000, 32'h0000_0001, 16'd3, -1, 1'b1, 32'h0000_0002, 49, 1'b0, 3};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0002, 16'd2, -1, 1'b0, 32'h0000_0001, 33, 1'b0, 2};
    tbl[3] = '{32'h0000_0055, 32'h0000_0003, 16'd2,  7, 1'b0, 32'h0000_0055, 12, 1'b1, 1};
    tbl[4] = '{32'h1234_5678, 32'h0000_0009, 16'd0, -1, 1'b0, 32'h0000_0055,  1, 1'b0, 0};
    tbl[5] = '{32'h0000_0077, 32'h0000_0001, 16'd2,  2, 1'b0, 32'h0000_0077,  3, 1'b1, 0};
    tbl[6] = '{32'h0000_0010, 32'h0000_0005, 16'd3, 14, 1'b0, 32'h0000_0010, 17, 1'b1, 1};
    tbl[7] = '{32'h0000_0100, 32'h0000_0010, 16'd3, 18, 1'b0, 32'h0000_0110, 19, 1'b1, 1};

    i_rst       = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_start = '0;
    i_cmd_step  = '0;
    i_cmd_count = '0;
    i_abort     = 1'b0;

    for (int i = 0; i < 3; i++) tick();
    check("reset state", 64'(actual()), 64'd0);
    i_rst = 1'b0;
    wait_ready("post-reset");

    // Reset in the middle of FIRE clears everything on the next edge.
    i_cmd_valid = 1'b1;
    i_cmd_start = 32'h1234_5678;
    i_cmd_step  = 32'h1;
    i_cmd_count = 16'd2;
    tick();
    i_cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("mid-fire trigger", 64'({o_trigger, o_busy, o_data}), 64'({1'b1, 1'b1, 32'h1234_5678}));
    i_rst = 1'b1;
    tick();
    check("reset mid-fire", 64'(actual()), 64'd0);
    tick();
    tick();
    check("reset held", 64'(actual()), 64'd0);
    i_rst = 1'b0;
    m_data = '0;
    m_idx  = '0;
    wait_ready("after mid-fire reset");

    // Abort while idle has no effect.
    i_abort = 1'b1;
    tick();
    tick();
    i_abort = 1'b0;
    check("idle abort ignored", 64'({o_busy, o_done, o_aborted, o_trigger, o_cmd_ready}), 64'(5'b00001));

    for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
